// File: rtl/gf_red_digit.sv
// gf_red_digit: digit-serial GF(2^m) polynomial reducer.
//
// Reduces a carry-less product of up to 2m bits modulo a polynomial of
// degree m (2 <= m <= DATA_WIDTH) selected per operation. DIGIT product bits
// are eliminated per REDUCE cycle. Illegal polynomials are flagged on out_err.
//
// Ports:
//   clk           clock
//   op_enable     synchronous active-low reset (low = reset)
//   in_valid      operands valid            in_ready   block can accept
//   polyn_grade   field degree m
//   polyn_red_in  reduction polynomial, bit i = coefficient of x^i
//   reduc_in      polynomial to reduce (bits >= 2m ignored)
//   out_valid     result valid              out_ready  consumer takes result
//   out           remainder, bits >= m are zero
//   out_err       qualifies out_valid: illegal polynomial
//   op_busy       high whenever not IDLE
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for operands, in_ready=1
// REDUCE | eliminating DIGIT bits per cycle; one extra cycle loads the result
// DONE   | out_valid=1, holding result until out_ready
module gf_red_digit #(
  parameter int DATA_WIDTH = 8,
  parameter int DIGIT      = 2
) (
  input  logic                          clk,
  input  logic                          op_enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  input  logic [DATA_WIDTH:0]           polyn_red_in,
  input  logic [2*DATA_WIDTH-1:0]       reduc_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out,
  output logic                          out_err,
  output logic                          op_busy
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int RW = 2 * DATA_WIDTH;
  localparam int KW = $clog2(RW) + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REDUCE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]            state_q;
  logic [GW-1:0]         m_q;
  logic [RW-1:0]         poly_q;
  logic [RW-1:0]         r_q;
  logic [KW-1:0]         k_q;
  logic [CW-1:0]         cnt_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  out_err_q;

  logic                  legal;
  logic [RW-1:0]         poly_msk;
  logic [RW-1:0]         red_msk;
  logic [CW-1:0]         n_steps;
  logic [KW-1:0]         k_start;
  logic [RW-1:0]         r_step;
  logic [DATA_WIDTH-1:0] res;

  // Operand conditioning at accept: polynomial bits above m and product
  // bits at or above 2m are dropped before they enter the datapath.
  always_comb begin
    legal    = 1'b0;
    poly_msk = '0;
    red_msk  = '0;
    for (int i = 0; i <= DATA_WIDTH; i++) begin
      if (i <= int'(polyn_grade)) poly_msk[i] = polyn_red_in[i];
      if ((i == int'(polyn_grade)) && polyn_red_in[i]) legal = 1'b1;
    end
    if ((int'(polyn_grade) < 2) || (int'(polyn_grade) > DATA_WIDTH)) legal = 1'b0;
    for (int i = 0; i < RW; i++) begin
      if (i < 2 * int'(polyn_grade)) red_msk[i] = reduc_in[i];
    end
    n_steps = CW'((int'(polyn_grade) + DIGIT - 1) / DIGIT);
    k_start = KW'(2 * int'(polyn_grade) - 1);
  end

  // One REDUCE step: indices k down to k-DIGIT+1, highest first, since each
  // XOR may set lower bits that a later index in the same digit must see.
  // Indices below m are left alone, which shortens the final digit.
  always_comb begin
    r_step = r_q;
    for (int p = RW - 1; p >= 0; p--) begin
      if ((p <= int'(k_q)) && (p > int'(k_q) - DIGIT) &&
          (p >= int'(m_q)) && r_step[p]) begin
        r_step = r_step ^ (poly_q << (p - int'(m_q)));
      end
    end
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(m_q)) res[i] = r_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!op_enable) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      poly_q    <= '0;
      r_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_q     <= '0;
      out_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            m_q     <= polyn_grade;
            poly_q  <= poly_msk;
            r_q     <= red_msk;
            k_q     <= k_start;
            state_q <= S_REDUCE;
            // An illegal polynomial runs zero steps, so it reaches DONE
            // one edge after accept with the error flag set.
            if (legal) begin
              cnt_q <= n_steps;
              err_q <= 1'b0;
            end else begin
              cnt_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        S_REDUCE: begin
          if (cnt_q != '0) begin
            r_q   <= r_step;
            k_q   <= k_q - KW'(DIGIT);
            cnt_q <= cnt_q - CW'(1);
          end else begin
            out_q     <= err_q ? '0 : res;
            out_err_q <= err_q;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = op_enable && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign op_busy   = (state_q != S_IDLE);
  assign out       = out_q;
  assign out_err   = out_err_q;

endmodule

// File: doc/gf_red_digit.md
Name: gf_red_digit

Overview:
- Digit-serial GF(2^m) polynomial reducer: takes a carry-less product of up to 2m bits and reduces it modulo a runtime-selected polynomial of degree m, 2 <= m <= DATA_WIDTH.
- Successor to the bit-serial reducer. Processes DIGIT bits per cycle, uses valid/ready handshakes on both sides, and flags illegal polynomials.
- Sits between the carry-less multiplier and downstream field-arithmetic consumers.

Parameters:
- DATA_WIDTH, 8, maximum field degree m.
- DIGIT, 2, product bits eliminated per REDUCE cycle (1..DATA_WIDTH).

Ports:
- clk  input  1  clock.
- op_enable  input  1  synchronous active-low reset (low = reset).
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- polyn_grade  input  $clog2(DATA_WIDTH)+1  degree m of the reduction polynomial.
- polyn_red_in  input  DATA_WIDTH+1  reduction polynomial; bit i = coefficient of x^i.
- reduc_in  input  2*DATA_WIDTH  polynomial to reduce.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  DATA_WIDTH  remainder; bits >= m are zero.
- out_err  output  1  qualifies out_valid: illegal polynomial.
- op_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: clk and op_enable form one clock domain; reset is synchronous and active-low. While op_enable=0 at a clk edge: state=IDLE, out=0, out_err=0, out_valid=0, op_busy=0, counter=0.
- Reset mid-operation aborts the operation with no output. in_ready=0 during reset.
- States:
  - IDLE: in_ready=1.
  - REDUCE.
  - DONE: out_valid=1.
- in_ready=1 only in IDLE. No accept is possible in DONE, even if out_ready=1 on the same edge.
- Accept at edge E0 (in_valid & in_ready):
  - latch m and the polynomial;
  - latch reduc_in with bits at index >= 2m masked to 0.
- Legality check at accept: polynomial is legal iff 2 <= m <= DATA_WIDTH and polyn_red_in[m]=1. Bits of polyn_red_in above m are ignored.
- Illegal polynomial: go straight to DONE; out_valid=1 after E0+1 with out=0 and out_err=1.
- Legal polynomial: N = ceil(m/DIGIT) REDUCE steps on edges E1..EN.
  - Working register r, 2*DATA_WIDTH bits. Step pointer k starts at 2m-1.
  - Each step handles k, k-1, ..., k-DIGIT+1 in order, skipping any index < m.
  - For each index i: if r[i]=1 then r ^= poly << (i-m).
  - Pointer then decrements by DIGIT.
- After edge EN+1: state=DONE, out=r[m-1:0] zero-extended, out_err=0, out_valid=1. Total latency: accept edge to out_valid = N+1 edges.
- DONE: out, out_err and out_valid hold stable while out_ready=0. Edge with out_ready=1 returns to IDLE with out_valid=0; out keeps its last value.
- in_valid and operand changes while busy are ignored; operands are fully captured at E0.
- m not a multiple of DIGIT: the last step processes fewer than DIGIT bits.
- Result equals reduc_in mod poly over GF(2) for any legal input.

Test Plan:
- AES case, DATA_WIDTH=8, DIGIT=2, m=8, poly=0x11B, reduc_in=0x2B79 → out=0xC1, out_err=0. out_valid rises 5 edges after accept; in_ready=0 until out taken.
- m=4, poly=0x13, reduc_in=0x007F → out=0x06 after 3 edges. Repeat with reduc_in=0xFF7F: bits >= 8 are masked, out=0x06.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out, out_valid and out_err stable, in_valid ignored. Release → out_valid drops next edge and in_ready rises.
- Illegal polynomials:
  - polyn_grade=1 → out_err=1, out=0 one edge after accept.
  - m=5, poly=0x03 (bit5 = 0) → same response.
- Reset mid-REDUCE: drive op_enable=0 for one edge → out_valid=0, out=0, state IDLE. A new operation then completes correctly.
- Randomized: DIGIT in {1,3,8}, all legal m, 1000 vectors against a bitwise long-division model → exact match, latency ceil(m/DIGIT)+1.
